exc_gen: RTL and testbench

// - Fetch-stage exception generator of the RV32 Linux-capable pipeline; sits between IF and decode.
// - Classifies the fetched instruction/PC each cycle: page fault, misaligned PC, illegal encoding, EBREAK, ECALL.
// - Registers one exception request plus a 4-bit cause code for the CSR/trap unit.
// - Squashed on redirect, frozen on stall, idle while the core waits in WFI.

---
 rtl/exc_gen.sv | 159 +++++++++++++++
 tb/tb_exc_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/exc_gen.sv
// Fetch-stage exception generator.
// Classifies each fetched word/PC and registers one trap request.
module exc_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic        csr_new_pc_req,
  input  logic        exe_new_pc_req,
  input  logic        wfi_req,
  input  logic        if_stall,
  input  logic        i_page_fault,
  output logic        exc_req_o,
  output logic [3:0]  exc_code_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_SRET   = 32'h1020_0073;
  localparam logic [31:0] I_WFI    = 32'h1050_0073;

  localparam logic [3:0] C_MISALIGN = 4'd0;
  localparam logic [3:0] C_ILLEGAL  = 4'd2;
  localparam logic [3:0] C_BREAK    = 4'd3;
  localparam logic [3:0] C_ECALL    = 4'd8;
  localparam logic [3:0] C_PFAULT   = 4'd12;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] funct5;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       legal;
  logic       req_d;
  logic [3:0] code_d;
  logic       flush;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign funct5 = instruction[31:27];
  assign rs2    = instruction[24:20];
  assign rd     = instruction[11:7];
  assign flush  = csr_new_pc_req | exe_new_pc_req;

  // Decode whether the fetched word is a supported RV32IMA+Zicsr encoding.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL:
        legal = 1'b1;
      OP_JALR:
        legal = (funct3 == 3'b000);
      OP_BRANCH:
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD:
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                (funct3 == 3'b010) || (funct3 == 3'b100) ||
                (funct3 == 3'b101);
      OP_STORE:
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                (funct3 == 3'b010);
      OP_IMM:
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) ||
                           (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      OP_OP:
        case (funct7)
          7'b0000000: legal = 1'b1;
          7'b0000001: legal = 1'b1;
          7'b0100000: legal = (funct3 == 3'b000) ||
                              (funct3 == 3'b101);
          default:    legal = 1'b0;
        endcase
      OP_MISC:
        legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_AMO:
        if (funct3 == 3'b010) begin
          case (funct5)
            5'b00000, 5'b00001, 5'b00011, 5'b00100,
            5'b01000, 5'b01100, 5'b10000, 5'b10100,
            5'b11000, 5'b11100: legal = 1'b1;
            5'b00010:           legal = (rs2 == 5'd0);
            default:            legal = 1'b0;
          endcase
        end
      OP_SYSTEM:
        case (funct3)
          3'b000:
            legal = (instruction == I_ECALL) ||
                    (instruction == I_EBREAK) ||
                    (instruction == I_MRET) ||
                    (instruction == I_SRET) ||
                    (instruction == I_WFI) ||
                    ((funct7 == 7'b0001001) && (rd == 5'd0));
          3'b100:  legal = 1'b0;
          default: legal = 1'b1;
        endcase
      default:
        legal = 1'b0;
    endcase
  end

  // Pick the highest-priority exception for this fetch slot.
  always_comb begin
    req_d  = 1'b1;
    code_d = 4'd0;
    priority case (1'b1)
      i_page_fault:              code_d = C_PFAULT;
      (pc[1:0] != 2'b00):        code_d = C_MISALIGN;
      !legal:                    code_d = C_ILLEGAL;
      (instruction == I_EBREAK): code_d = C_BREAK;
      (instruction == I_ECALL):  code_d = C_ECALL;
      default: begin
        req_d  = 1'b0;
        code_d = 4'd0;
      end
    endcase
  end

  // Output register: flush beats stall, stall holds, WFI idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_req_o  <= 1'b0;
      exc_code_o <= 4'd0;
    end else if (flush) begin
      exc_req_o  <= 1'b0;
      exc_code_o <= 4'd0;
    end else if (if_stall) begin
      exc_req_o  <= exc_req_o;
      exc_code_o <= exc_code_o;
    end else if (wfi_req) begin
      exc_req_o  <= 1'b0;
      exc_code_o <= 4'd0;
    end else begin
      exc_req_o  <= req_d;
      exc_code_o <= code_d;
    end
  end

endmodule

// File: tb/tb_exc_gen.sv
// Directed bench for exc_gen.
// Each step drives inputs, clocks once, and checks the registered outputs.
module tb_exc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        csr_new_pc_req;
  logic        exe_new_pc_req;
  logic        wfi_req;
  logic        if_stall;
  logic        i_page_fault;
  logic        exc_req_o;
  logic [3:0]  exc_code_o;

  int checks = 0;
  int errors = 0;

  exc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .instruction    (instruction),
    .pc             (pc),
    .csr_new_pc_req (csr_new_pc_req),
    .exe_new_pc_req (exe_new_pc_req),
    .wfi_req        (wfi_req),
    .if_stall       (if_stall),
    .i_page_fault   (i_page_fault),
    .exc_req_o      (exc_req_o),
    .exc_code_o     (exc_code_o)
  );

  always #5 clk = ~clk;

  // Drive one fetch slot, clock it, then compare both outputs.
  task automatic step(
    input string       tag,
    input logic        r,
    input logic [31:0] ins,
    input logic [31:0] p,
    input logic        csr,
    input logic        exe,
    input logic        wfi,
    input logic        stl,
    input logic        pf,
    input logic        exp_req,
    input logic [3:0]  exp_code
  );
    @(negedge clk);
    rst            = r;
    instruction    = ins;
    pc             = p;
    csr_new_pc_req = csr;
    exe_new_pc_req = exe;
    wfi_req        = wfi;
    if_stall       = stl;
    i_page_fault   = pf;
    @(posedge clk);
    #1;
    checks++;
    assert (exc_req_o === exp_req) else begin
      errors++;
      $error("FAIL %s req got %b want %b", tag, exc_req_o, exp_req);
    end
    checks++;
    assert (exc_code_o === exp_code) else begin
      errors++;
      $error("FAIL %s code got %0d want %0d", tag, exc_code_o, exp_code);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PCA = 32'h0000_1000;

  initial begin
    rst = 1'b1; instruction = 32'h0; pc = 32'h0;
    csr_new_pc_req = 1'b0; exe_new_pc_req = 1'b0;
    wfi_req = 1'b0; if_stall = 1'b0; i_page_fault = 1'b0;

    // tag, rst, instr, pc, csr, exe, wfi, stall, pf, req, code
    step("rst0", 1, 32'h0, 32'h1002, 0, 0, 0, 0, 1, 0, 0);
    step("rst1", 1, 32'hFFFF_FFFF, PCA, 0, 0, 0, 1, 0, 0, 0);
    step("nop", 0, NOP, PCA, 0, 0, 0, 0, 0, 0, 0);
    step("ecall", 0, 32'h0000_0073, PCA, 0, 0, 0, 0, 0, 1, 8);
    step("ebreak", 0, 32'h0010_0073, PCA, 0, 0, 0, 0, 0, 1, 3);
    step("misal", 0, NOP, 32'h1002, 0, 0, 0, 0, 0, 1, 0);
    step("pfault", 0, NOP, 32'h1002, 0, 0, 0, 0, 1, 1, 12);
    step("misal_ill", 0, 32'h0, 32'h1001, 0, 0, 0, 0, 0, 1, 0);
    step("zero", 0, 32'h0, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("ones", 0, 32'hFFFF_FFFF, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("op6b", 0, 32'h0000_406B, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("sys100", 0, 32'h0000_4073, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("mul", 0, 32'h02A5_0533, PCA, 0, 0, 0, 0, 0, 0, 0);
    step("mret", 0, 32'h3020_0073, PCA, 0, 0, 0, 0, 0, 0, 0);
    step("srai", 0, 32'h4000_5013, PCA, 0, 0, 0, 0, 0, 0, 0);
    step("slli_bad", 0, 32'h4000_1013, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("lr_ok", 0, 32'h1000_202F, PCA, 0, 0, 0, 0, 0, 0, 0);
    step("lr_rs2", 0, 32'h1010_202F, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("sfence", 0, 32'h1200_0073, PCA, 0, 0, 0, 0, 0, 0, 0);
    step("br010", 0, 32'h0000_2063, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("exe_fl", 0, 32'h0, PCA, 0, 1, 0, 0, 0, 0, 0);
    step("set1", 0, 32'h0, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("exe_stl", 0, 32'h0, PCA, 0, 1, 0, 1, 0, 0, 0);
    step("set2", 0, 32'h0, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("csr_fl", 0, 32'h0, PCA, 1, 0, 0, 0, 0, 0, 0);
    step("set3", 0, 32'h0, PCA, 0, 0, 0, 0, 0, 1, 2);
    step("stall0", 0, NOP, PCA, 0, 0, 0, 1, 0, 1, 2);
    step("stall1", 0, 32'h0000_0073, PCA, 0, 0, 1, 1, 0, 1, 2);
    step("wfi", 0, NOP, PCA, 0, 0, 1, 0, 0, 0, 0);
    step("wfi_ill", 0, 32'h0, PCA, 0, 0, 1, 0, 0, 0, 0);
    step("set4", 0, 32'h0010_0073, PCA, 0, 0, 0, 0, 0, 1, 3);
    step("rst_stl", 1, 32'h0, PCA, 0, 0, 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
